// File: rtl/backend_pkg.sv
// backend_pkg: shared types and sizes for the dispatch -> scheduler path.
//   RS_ENTRIES : reservation-station depth
//   NUM_PREGS  : physical register count (preg 0 is hardwired zero)
//   NUM_SRCS   : source operands per instruction
//   disp_packet_t : renamed instruction as carried from rename into the RS
package backend_pkg;

  localparam int RS_ENTRIES = 16;
  localparam int NUM_PREGS  = 64;
  localparam int NUM_SRCS   = 2;

  localparam int RS_IDX_W = $clog2(RS_ENTRIES);
  localparam int PREG_W   = $clog2(NUM_PREGS);

  typedef logic [RS_IDX_W-1:0]   rs_idx_t;
  typedef logic [PREG_W-1:0]     preg_t;
  typedef logic [RS_ENTRIES-1:0] rs_mask_t;

  typedef struct packed {
    preg_t [NUM_SRCS-1:0] src_preg;
    logic  [NUM_SRCS-1:0] src_used;
    preg_t                dst_preg;
    logic                 dst_used;
    logic  [31:0]         payload;
  } disp_packet_t;

  // One-hot RS entry mask for a given entry index.
  function automatic rs_mask_t rs_onehot(input rs_idx_t i);
    return rs_mask_t'(1) << i;
  endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// dispatch_scheduler_if: bundle between dispatch and the reservation station.
//   dispatch side drives : disp_valid, dependency_mask, disp_pkt
//   scheduler side drives: rs_entry_idx (currently free entry), rs_full
// An instruction is written into the RS in every cycle where disp_valid is 1;
// dispatch only raises disp_valid when rs_full is 0, so there is no separate
// ready signal on this side.
interface dispatch_scheduler_if;
  import backend_pkg::*;

  logic         disp_valid;
  rs_mask_t     dependency_mask;
  disp_packet_t disp_pkt;
  rs_idx_t      rs_entry_idx;
  logic         rs_full;

  modport dispatch (
    output disp_valid,
    output dependency_mask,
    output disp_pkt,
    input  rs_entry_idx,
    input  rs_full
  );

  modport scheduler (
    input  disp_valid,
    input  dependency_mask,
    input  disp_pkt,
    output rs_entry_idx,
    output rs_full
  );

endinterface

// File: rtl/producer_table.sv
// producer_table: maps each physical register to the RS entry that will write it.
//   clk, rst     : clock, async active-high reset (clears all valid bits)
//   flush        : clears all valid bits at the next edge
//   ready_mask   : RS entries completing this cycle
//   rd_preg      : NUM_SRCS read ports (preg index)
//   rd_hit       : producer is live and not completing this cycle
//   rd_idx       : RS entry of that producer
//   wr_en/wr_preg/wr_idx : record a new producer
module producer_table
  import backend_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  rs_mask_t                ready_mask,
  input  preg_t [NUM_SRCS-1:0]    rd_preg,
  output logic  [NUM_SRCS-1:0]    rd_hit,
  output rs_idx_t [NUM_SRCS-1:0]  rd_idx,
  input  logic                    wr_en,
  input  preg_t                   wr_preg,
  input  rs_idx_t                 wr_idx
);

  logic [NUM_PREGS-1:0] pv;
  rs_idx_t              idx [NUM_PREGS];

  // Read ports bypass the same-cycle completion so a producer finishing now
  // never shows up as a dependency. Preg 0 never has a producer.
  always_comb begin
    rd_hit = '0;
    rd_idx = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      rd_idx[s] = idx[rd_preg[s]];
      rd_hit[s] = (rd_preg[s] != '0) && pv[rd_preg[s]] &&
                  !ready_mask[idx[rd_preg[s]]];
    end
  end

  // Clear-by-mask first, then the write, so a same-cycle write to a preg
  // whose old producer is completing keeps the new producer live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else if (flush) begin
      pv <= '0;
    end else begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        if (pv[p] && ready_mask[idx[p]]) pv[p] <= 1'b0;
      end
      if (wr_en) pv[wr_preg] <= 1'b1;
    end
  end

  // Index storage needs no reset: it is only read when pv is set.
  always_ff @(posedge clk) begin
    if (wr_en) idx[wr_preg] <= wr_idx;
  end

endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: takes one renamed instruction per cycle, computes its
// dependency mask against in-flight producers and writes it into the RS.
//   clk, rst   : clock, async active-high reset
//   ren_valid  : rename offers ren_pkt
//   ren_ready  : dispatch accepts ren_pkt this cycle
//   ren_pkt    : renamed instruction
//   ready_mask : RS entries completing this cycle (OR over all pipes)
//   flush      : squash the held instruction and all producer tracking
//   disp_if    : dispatch modport towards the scheduler
//
// Handshakes: a transfer on the rename side happens in every cycle where
// ren_valid && ren_ready are both 1; ren_ready does not depend on ren_valid.
// On the RS side disp_valid is itself the write strobe.
module dispatch_unit
  import backend_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ren_valid,
  output logic                      ren_ready,
  input  disp_packet_t              ren_pkt,
  input  rs_mask_t                  ready_mask,
  input  logic                      flush,
  dispatch_scheduler_if.dispatch    disp_if
);

  logic                   hold_valid;
  disp_packet_t           hold_pkt;
  logic                   fire;
  logic                   load;
  logic [NUM_SRCS-1:0]    rd_hit;
  rs_idx_t [NUM_SRCS-1:0] rd_idx;
  rs_mask_t               dep_mask;
  logic                   wr_en;

  assign fire      = hold_valid && !disp_if.rs_full && !flush;
  assign ren_ready = !flush && (!hold_valid || fire);
  assign load      = ren_valid && ren_ready;

  // Read happens on the old table contents, so an instruction that reads and
  // writes the same preg depends on the previous producer.
  assign wr_en = fire && hold_pkt.dst_used && (hold_pkt.dst_preg != '0);

  producer_table u_table (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ready_mask (ready_mask),
    .rd_preg    (hold_pkt.src_preg),
    .rd_hit     (rd_hit),
    .rd_idx     (rd_idx),
    .wr_en      (wr_en),
    .wr_preg    (hold_pkt.dst_preg),
    .wr_idx     (disp_if.rs_entry_idx)
  );

  // Duplicate sources OR into the same bit.
  always_comb begin
    dep_mask = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      if (hold_valid && hold_pkt.src_used[s] && rd_hit[s]) begin
        dep_mask = dep_mask | rs_onehot(rd_idx[s]);
      end
    end
  end

  assign disp_if.disp_valid      = fire;
  assign disp_if.dependency_mask = dep_mask;
  assign disp_if.disp_pkt        = hold_pkt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_valid <= 1'b1;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) hold_pkt <= ren_pkt;
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_dispatch_unit;
  import backend_pkg::*;

  logic         clk;
  logic         rst;
  logic         ren_valid;
  logic         ren_ready;
  disp_packet_t ren_pkt;
  rs_mask_t     ready_mask;
  logic         flush;

  dispatch_scheduler_if disp_if ();

  dispatch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ren_valid  (ren_valid),
    .ren_ready  (ren_ready),
    .ren_pkt    (ren_pkt),
    .ready_mask (ready_mask),
    .flush      (flush),
    .disp_if    (disp_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_prod[p] = RS entry of the live producer of preg p, or -1 if none.
  logic         model_en;
  logic         m_hold_valid;
  disp_packet_t m_hold;
  int           m_prod [NUM_PREGS];
  bit           busy   [RS_ENTRIES];
  logic         ef, er;
  rs_mask_t     em;

  task automatic model_reset();
    m_hold_valid = 1'b0;
    for (int p = 0; p < NUM_PREGS; p++) m_prod[p] = -1;
    for (int e = 0; e < RS_ENTRIES; e++) busy[e] = 1'b0;
  endtask

  function automatic rs_mask_t model_mask();
    rs_mask_t m;
    int p;
    m = '0;
    if (m_hold_valid) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        p = int'(m_hold.src_preg[s]);
        if (m_hold.src_used[s] && p != 0 && m_prod[p] >= 0 && !ready_mask[m_prod[p]])
          m[m_prod[p]] = 1'b1;
      end
    end
    return m;
  endfunction

  // Single compare process: outputs are settled by the falling edge; the
  // model then advances to what the next rising edge must produce.
  always @(negedge clk) begin
    if (!rst && model_en) begin
      ef = m_hold_valid && !disp_if.rs_full && !flush;
      er = !flush && (!m_hold_valid || ef);
      em = model_mask();
      check("disp_valid", {63'd0, disp_if.disp_valid}, {63'd0, ef});
      check("ren_ready", {63'd0, ren_ready}, {63'd0, er});
      check("dep_mask", 64'(disp_if.dependency_mask), 64'(em));
      if (ef) check("disp_pkt", 64'(disp_if.disp_pkt), 64'(m_hold));

      for (int p = 0; p < NUM_PREGS; p++)
        if (m_prod[p] >= 0 && ready_mask[m_prod[p]]) m_prod[p] = -1;
      for (int e = 0; e < RS_ENTRIES; e++)
        if (ready_mask[e]) busy[e] = 1'b0;
      if (ef) begin
        busy[disp_if.rs_entry_idx] = 1'b1;
        if (m_hold.dst_used && m_hold.dst_preg != '0)
          m_prod[m_hold.dst_preg] = int'(disp_if.rs_entry_idx);
      end
      if (flush) begin
        for (int p = 0; p < NUM_PREGS; p++) m_prod[p] = -1;
        for (int e = 0; e < RS_ENTRIES; e++) busy[e] = 1'b0;
        m_hold_valid = 1'b0;
      end else if (ren_valid && er) begin
        m_hold       = ren_pkt;
        m_hold_valid = 1'b1;
      end else if (ef) begin
        m_hold_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren_valid            = 1'b0;
    ready_mask           = '0;
    flush                = 1'b0;
    disp_if.rs_full      = 1'b0;
    disp_if.rs_entry_idx = '0;
  endtask

  function automatic disp_packet_t mk(input int s0, input bit u0, input int s1, input bit u1,
                                      input int d, input bit du, input logic [31:0] pl);
    disp_packet_t p;
    p.src_preg[0] = preg_t'(s0);
    p.src_preg[1] = preg_t'(s1);
    p.src_used    = {u1, u0};
    p.dst_preg    = preg_t'(d);
    p.dst_used    = du;
    p.payload     = pl;
    return p;
  endfunction

  function automatic disp_packet_t rand_pkt();
    return mk($urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int       nfree;
    int       k;
    rs_mask_t rm;

    model_en = 1'b0;
    rst      = 1'b1;
    ren_pkt  = '0;
    idle();
    model_reset();
    #2;
    check("rst_disp_valid", {63'd0, disp_if.disp_valid}, 64'd0);
    check("rst_dep_mask", 64'(disp_if.dependency_mask), 64'd0);
    check("rst_ren_ready", {63'd0, ren_ready}, 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_en = 1'b1;

    // Back-to-back dependence: I0 (dst p5) -> entry 3, then I1 (src p5, p0).
    tick(); ren_valid = 1; ren_pkt = mk(0, 0, 0, 0, 5, 1, 32'hA000_0000);
    tick(); ren_pkt = mk(5, 1, 0, 1, 0, 0, 32'hA000_0001); disp_if.rs_entry_idx = 3;
    #2 check("b2b_i0_valid", {63'd0, disp_if.disp_valid}, 64'd1);
    tick(); ren_valid = 0; disp_if.rs_entry_idx = 7;
    #2 check("b2b_mask", 64'(disp_if.dependency_mask), 64'h0008);

    // Same-cycle completion bypass, then the table entry is gone.
    tick(); ren_valid = 1; ren_pkt = mk(5, 1, 0, 0, 0, 0, 32'hB000_0000);
    tick(); ren_valid = 0; ready_mask = 16'h0008; disp_if.rs_entry_idx = 8;
    #2 check("bypass_mask", 64'(disp_if.dependency_mask), 64'h0000);
    tick(); ready_mask = '0; ren_valid = 1; ren_pkt = mk(5, 1, 5, 1, 0, 0, 32'hB000_0001);
    tick(); ren_valid = 0; disp_if.rs_entry_idx = 10;
    #2 check("cleared_mask", 64'(disp_if.dependency_mask), 64'h0000);

    // Full stall: p7 -> entry 9, consumer held while rs_full for 4 cycles.
    tick(); ren_valid = 1; ren_pkt = mk(0, 0, 0, 0, 7, 1, 32'hC000_0000);
    tick(); ren_pkt = mk(7, 1, 0, 0, 0, 0, 32'hC000_0001); disp_if.rs_entry_idx = 9;
    tick(); disp_if.rs_full = 1; ren_pkt = mk(0, 0, 0, 0, 0, 0, 32'hC000_0002);
    #2 check("stall1_mask", 64'(disp_if.dependency_mask), 64'h0200);
    check("stall1_ready", {63'd0, ren_ready}, 64'd0);
    tick(); ready_mask = 16'h0200;
    #2 check("stall2_mask", 64'(disp_if.dependency_mask), 64'h0000);
    check("stall2_valid", {63'd0, disp_if.disp_valid}, 64'd0);
    tick(); ready_mask = '0;
    tick();
    #2 check("stall4_ready", {63'd0, ren_ready}, 64'd0);
    tick(); disp_if.rs_full = 0; disp_if.rs_entry_idx = 13;
    #2 check("stall_fire_valid", {63'd0, disp_if.disp_valid}, 64'd1);
    check("stall_fire_mask", 64'(disp_if.dependency_mask), 64'h0000);
    tick(); ren_valid = 0; disp_if.rs_entry_idx = 14;

    // Self and duplicate sources: p4 -> entry 2, then src p4,p4 dst p4 -> entry 6.
    tick(); ren_valid = 1; ren_pkt = mk(0, 0, 0, 0, 4, 1, 32'hD000_0000);
    tick(); ren_pkt = mk(4, 1, 4, 1, 4, 1, 32'hD000_0001); disp_if.rs_entry_idx = 2;
    tick(); ren_pkt = mk(4, 1, 0, 0, 0, 0, 32'hD000_0002); disp_if.rs_entry_idx = 6;
    #2 check("self_dup_mask", 64'(disp_if.dependency_mask), 64'h0004);
    tick(); ren_valid = 0; disp_if.rs_entry_idx = 15;
    #2 check("self_new_idx", 64'(disp_if.dependency_mask), 64'h0040);

    // Write beats clear: p8 -> entry 1, then p8 -> entry 11 while entry 1 completes.
    tick(); ren_valid = 1; ren_pkt = mk(0, 0, 0, 0, 8, 1, 32'hE000_0000);
    tick(); ren_pkt = mk(0, 0, 0, 0, 8, 1, 32'hE000_0001); disp_if.rs_entry_idx = 1;
    tick(); ren_pkt = mk(8, 1, 0, 0, 0, 0, 32'hE000_0002); ready_mask = 16'h0002;
    disp_if.rs_entry_idx = 11;
    tick(); ren_valid = 0; ready_mask = '0; disp_if.rs_entry_idx = 0;
    #2 check("write_wins_mask", 64'(disp_if.dependency_mask), 64'h0800);

    // Flush with a held instruction and three live producers.
    tick(); ren_valid = 1; ren_pkt = mk(0, 0, 0, 0, 10, 1, 32'hF000_0000);
    tick(); ren_pkt = mk(0, 0, 0, 0, 11, 1, 32'hF000_0001); disp_if.rs_entry_idx = 4;
    tick(); ren_pkt = mk(0, 0, 0, 0, 12, 1, 32'hF000_0002); disp_if.rs_entry_idx = 5;
    tick(); ren_pkt = mk(10, 1, 11, 1, 0, 0, 32'hF000_0003); disp_if.rs_entry_idx = 12;
    tick(); flush = 1; ren_pkt = mk(10, 1, 12, 1, 0, 0, 32'hF000_0004);
    #2 check("flush_valid", {63'd0, disp_if.disp_valid}, 64'd0);
    check("flush_ready", {63'd0, ren_ready}, 64'd0);
    tick(); flush = 0;
    #2 check("post_flush_ready", {63'd0, ren_ready}, 64'd1);
    tick(); ren_pkt = mk(11, 1, 12, 1, 0, 0, 32'hF000_0005); disp_if.rs_entry_idx = 3;
    #2 check("post_flush_mask_a", 64'(disp_if.dependency_mask), 64'h0000);
    tick(); ren_valid = 0; disp_if.rs_entry_idx = 7;
    #2 check("post_flush_mask_b", 64'(disp_if.dependency_mask), 64'h0000);

    // Async reset mid-cycle while an instruction is about to fire.
    tick(); ren_valid = 1; ren_pkt = mk(0, 1, 0, 0, 0, 0, 32'h1234_5678);
    tick(); ren_valid = 0; disp_if.rs_full = 1;
    tick(); disp_if.rs_full = 0;
    #1 check("pre_rst_valid", {63'd0, disp_if.disp_valid}, 64'd1);
    rst = 1;
    #1 check("async_rst_valid", {63'd0, disp_if.disp_valid}, 64'd0);
    check("async_rst_ready", {63'd0, ren_ready}, 64'd1);
    check("async_rst_mask", 64'(disp_if.dependency_mask), 64'd0);
    model_reset();
    idle();
    tick();
    tick(); rst = 0;

    // Randomized traffic with a bench-side scheduler that only hands out free entries.
    for (int c = 0; c < 3000; c++) begin
      tick();
      flush = ($urandom_range(0, 99) < 3);
      rm    = '0;
      nfree = 0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
        if (busy[e]) begin
          if ($urandom_range(0, 3) == 0) rm[e] = 1'b1;
        end else begin
          nfree++;
        end
      end
      ready_mask = rm;
      if (nfree == 0) begin
        disp_if.rs_full      = 1'b1;
        disp_if.rs_entry_idx = rs_idx_t'($urandom_range(0, RS_ENTRIES - 1));
      end else begin
        disp_if.rs_full = ($urandom_range(0, 4) == 0);
        k = $urandom_range(0, nfree - 1);
        for (int e = 0; e < RS_ENTRIES; e++) begin
          if (!busy[e]) begin
            if (k == 0) disp_if.rs_entry_idx = rs_idx_t'(e);
            k--;
          end
        end
      end
      ren_valid = ($urandom_range(0, 9) < 7);
      ren_pkt   = rand_pkt();
    end

    tick();
    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
